mul9_ppgen: RTL

//   Registered partial-product generator feeding the 9x9 GPC compressor tree (src0..src16 column inputs).

---
 rtl/mul9_pkg.sv | 21 ++
 rtl/mul9_skid2.sv | 72 +++++++
 rtl/mul9_ppgen.sv | 104 ++++++++++
 3 files changed

// File: rtl/mul9_pkg.sv
// Shared constants and column-geometry helpers for the 9x9 partial-product array.
// The compressor wrapper and the bench also use col_off/col_h.
package mul9_pkg;

   localparam int PP_W    = 9;
   localparam int PP_COLS = 17;
   localparam int PP_BITS = 81;

   // Column k of a 9x9 AND array holds min(k+1, 17-k) bits.
   function automatic int col_h(input int k);
      return ((k + 1) < (PP_COLS - k)) ? (k + 1) : (PP_COLS - k);
   endfunction

   function automatic int col_off(input int k);
      int s;
      s = 0;
      for (int m = 0; m < k; m++) s = s + col_h(m);
      return s;
   endfunction

endpackage

// File: rtl/mul9_skid2.sv
// Two-entry valid/ready skid buffer. When empty, an arriving word is presented
// on the head the same cycle so the consumer can take it without a bubble.
module mul9_skid2 #(
   parameter int DW = 22
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          head_valid,
   input  logic          head_ready,
   output logic [DW-1:0] head_data
);

   // Handshake: a word moves on a port in any cycle where its valid and ready are
   // both high; in_ready depends on stored state and rst only, never on head_ready.
   logic [1:0]    occ_q, occ_d;
   logic [DW-1:0] s0_q, s0_d;
   logic [DW-1:0] s1_q, s1_d;
   logic          push, pop, stored;

   assign in_ready = (occ_q != 2'd2) & ~rst;

   always_comb begin
      push       = in_valid & in_ready;
      stored     = (occ_q != 2'd0);
      head_valid = stored | push;
      head_data  = stored ? s0_q : in_data;
      pop        = head_valid & head_ready;
      s0_d       = s0_q;
      s1_d       = s1_q;
      occ_d      = occ_q;
      case (occ_q)
         2'd0: begin
            if (push & ~pop) begin
               s0_d  = in_data;
               occ_d = 2'd1;
            end
         end
         2'd1: begin
            if (push & pop) begin
               s0_d = in_data;
            end else if (push) begin
               s1_d  = in_data;
               occ_d = 2'd2;
            end else if (pop) begin
               occ_d = 2'd0;
            end
         end
         default: begin
            if (pop) begin
               s0_d  = s1_q;
               occ_d = 2'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= 2'd0;
         s0_q  <= '0;
         s1_q  <= '0;
      end else begin
         occ_q <= occ_d;
         s0_q  <= s0_d;
         s1_q  <= s1_d;
      end
   end

endmodule

// File: rtl/mul9_ppgen.sv
// Registered 9x9 partial-product generator: skid-buffered operands, AND array,
// column-packed output register with tag, zero flag and accept counter.
module mul9_ppgen
   import mul9_pkg::*;
#(
   parameter int W     = 9,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_a,
   input  logic [W-1:0]       in_b,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PP_BITS-1:0] pp_flat,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_zero,
   output logic [CNT_W-1:0]   acc_cnt
);

   localparam int PL_W = 2 * W + TAG_W;

   logic               head_valid, head_ready, load;
   logic [PL_W-1:0]    head_data;
   logic [W-1:0]       h_a, h_b;
   logic [TAG_W-1:0]   h_tag;
   logic [PP_BITS-1:0] pp_comb;

   logic [PP_BITS-1:0] pp_q, pp_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               zero_q, zero_d;
   logic               ov_q, ov_d;
   logic [CNT_W-1:0]   acc_q, acc_d;

   mul9_skid2 #(.DW(PL_W)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    ({in_tag, in_b, in_a}),
      .head_valid (head_valid),
      .head_ready (head_ready),
      .head_data  (head_data)
   );

   assign h_a   = head_data[W-1:0];
   assign h_b   = head_data[2*W-1:W];
   assign h_tag = head_data[PL_W-1:2*W];

   // Within a column, bits are ordered by increasing multiplicand index i.
   for (genvar k = 0; k < PP_COLS; k++) begin : g_col
      for (genvar j = 0; j < col_h(k); j++) begin : g_bit
         localparam int I = j + ((k > PP_W - 1) ? (k - (PP_W - 1)) : 0);
         assign pp_comb[col_off(k) + j] = h_a[I] & h_b[k - I];
      end
   end

   assign head_ready = ~ov_q | out_ready;
   assign load       = head_valid & head_ready;

   always_comb begin
      pp_d   = pp_q;
      tag_d  = tag_q;
      zero_d = zero_q;
      ov_d   = ov_q;
      acc_d  = acc_q;
      if (load) begin
         pp_d   = pp_comb;
         tag_d  = h_tag;
         zero_d = (h_a == '0) | (h_b == '0);
         ov_d   = 1'b1;
      end else if (out_ready) begin
         ov_d = 1'b0;
      end
      if (in_valid & in_ready) acc_d = acc_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pp_q   <= '0;
         tag_q  <= '0;
         zero_q <= 1'b0;
         ov_q   <= 1'b0;
         acc_q  <= '0;
      end else begin
         pp_q   <= pp_d;
         tag_q  <= tag_d;
         zero_q <= zero_d;
         ov_q   <= ov_d;
         acc_q  <= acc_d;
      end
   end

   assign pp_flat   = pp_q;
   assign out_tag   = tag_q;
   assign out_zero  = zero_q;
   assign out_valid = ov_q;
   assign acc_cnt   = acc_q;

endmodule
